// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: state codes, address-byte layout and byte-lane helper for the SPI burst sequencer
package spi_seq_pkg;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_ADDR      = 3'd2;
  localparam logic [2:0] S_ADDR_WAIT = 3'd3;
  localparam logic [2:0] S_DATA      = 3'd4;
  localparam logic [2:0] S_DATA_WAIT = 3'd5;
  localparam logic [2:0] S_CLOSE     = 3'd6;
  localparam logic [2:0] S_GAP       = 3'd7;
  localparam int RW_BIT = 7;
  localparam int ADDR_MSB = 1;
  localparam logic [7:0] DUMMY_BYTE_DEF = 8'hFF;
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/spi_seq_cycle_cnt.sv
// spi_seq_cycle_cnt: loadable down-counter shared by the SS setup and SS gap phases
module spi_seq_cycle_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset) cnt <= '1;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/spi_reg_burst_sequencer.sv
// spi_reg_burst_sequencer: turns a register-burst command into an SS-framed SPI byte stream
module spi_reg_burst_sequencer
  import spi_seq_pkg::*;
#(
  parameter int SS_SETUP_CYC = 1,
  parameter int SS_GAP_CYC = 5,
  parameter logic [7:0] DUMMY_BYTE = DUMMY_BYTE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_addr,
  input  logic [1:0]  cmd_len,
  input  logic        cmd_cpol,
  input  logic        cmd_cpha,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        CPOL,
  output logic        CPHA,
  output logic        start,
  output logic [7:0]  tx_data,
  input  logic [7:0]  rx_data,
  input  logic        done,
  input  logic        ready,
  output logic        SS
);
  logic [2:0] state;
  logic w;
  logic [1:0] addr, len, idx, nidx;
  logic [31:0] wdata;
  logic [7:0] ab, nbyte, cnt_val;
  logic cnt_load, cnt_zero;
  spi_seq_cycle_cnt #(.W(8)) u_cnt (
    .clk(clk), .reset(reset), .load(cnt_load), .load_val(cnt_val), .zero(cnt_zero)
  );
  assign cmd_ready = state == S_IDLE;
  assign busy = !cmd_ready;
  assign rsp_valid = state == S_CLOSE;
  assign SS = !(state inside {S_SETUP, S_ADDR, S_ADDR_WAIT, S_DATA, S_DATA_WAIT});
  assign start = (state == S_ADDR || state == S_DATA) && ready;
  assign cnt_load = (cmd_valid && cmd_ready) || state == S_CLOSE;
  assign cnt_val = cmd_ready ? 8'(SS_SETUP_CYC - 1) : 8'(SS_GAP_CYC - 1);
  assign nidx = state == S_ADDR_WAIT ? 2'd0 : idx + 2'd1;
  assign nbyte = w ? byte_lane(wdata, nidx) : DUMMY_BYTE;
  always_comb begin
    ab = '0;
    ab[RW_BIT] = w;
    ab[ADDR_MSB:0] = addr;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      w <= 1'b0;
      addr <= '0;
      len <= '0;
      idx <= '0;
      wdata <= '0;
      CPOL <= 1'b0;
      CPHA <= 1'b0;
      tx_data <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          w <= cmd_write;
          addr <= cmd_addr;
          len <= cmd_len;
          wdata <= cmd_wdata;
          CPOL <= cmd_cpol;
          CPHA <= cmd_cpha;
          idx <= '0;
          rsp_rdata <= '0;
          state <= S_SETUP;
        end
        S_SETUP: if (cnt_zero) begin
          tx_data <= ab;
          state <= S_ADDR;
        end
        S_ADDR: if (ready) state <= S_ADDR_WAIT;
        S_ADDR_WAIT: if (done) begin
          tx_data <= nbyte;
          state <= S_DATA;
        end
        S_DATA: if (ready) state <= S_DATA_WAIT;
        S_DATA_WAIT: if (done) begin
          if (!w) rsp_rdata[{idx, 3'b000} +: 8] <= rx_data;
          if (idx == len) state <= S_CLOSE;
          else begin
            idx <= nidx;
            tx_data <= nbyte;
            state <= S_DATA;
          end
        end
        S_CLOSE: state <= S_GAP;
        default: if (cnt_zero) state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_reg_burst_sequencer.sv
// tb_spi_reg_burst_sequencer: directed and random bursts against an SPI master/slave byte model
module tb_spi_reg_burst_sequencer;
  localparam int GAP = 5;
  logic clk = 0, reset = 0, cmd_valid = 0, cmd_write = 0, cmd_cpol = 0, cmd_cpha = 0;
  logic [1:0] cmd_addr = 0, cmd_len = 0;
  logic [31:0] cmd_wdata = 0;
  logic cmd_ready, rsp_valid, busy, CPOL, CPHA, start, SS;
  logic [31:0] rsp_rdata;
  logic [7:0] tx_data;
  logic [7:0] rx_data = 0;
  logic done_m = 0, stray = 0, ready = 1, done;
  assign done = done_m | stray;
  int total = 0, passed = 0, fails = 0;
  logic [7:0] mosi[$], exp_q[$];
  logic [31:0] exp_rd;
  logic [7:0] sregs[4] = '{default: 8'h00};
  logic [7:0] mirror[4] = '{default: 8'h00};
  int sidx = 0, m_a;
  logic srw = 0;
  logic [1:0] saddr = 0;
  logic [7:0] m_b, m_r;
  int rsp_cnt = 0, ss_rise = 0, hi_run = 0, last_gap = 0, bad_start = 0, nr_low = 0;
  logic [31:0] rsp_last = 0;
  logic ss_prev = 1;

  spi_reg_burst_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_cpol(cmd_cpol),
    .cmd_cpha(cmd_cpha), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .CPOL(CPOL), .CPHA(CPHA), .start(start), .tx_data(tx_data),
    .rx_data(rx_data), .done(done), .ready(ready), .SS(SS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // bus observer: SS framing, rsp pulses, start legality
  initial forever begin
    @(negedge clk);
    if (start && !ready) bad_start++;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_last = rsp_rdata;
      nr_low = 0;
    end
    if (SS && busy && !cmd_ready) nr_low++;
    if (SS && !ss_prev) ss_rise++;
    if (SS) hi_run++;
    else begin
      if (ss_prev) last_gap = hi_run;
      hi_run = 0;
    end
    ss_prev = SS;
  end

  // SPI master + register slave at byte level
  initial forever begin
    @(negedge clk);
    if (SS) sidx = 0;
    if (start) begin
      m_b = tx_data;
      mosi.push_back(m_b);
      m_r = 8'h00;
      if (sidx == 0) begin
        srw = m_b[7];
        saddr = m_b[1:0];
      end else begin
        m_a = (int'(saddr) + sidx - 1) % 4;
        if (srw) sregs[m_a] = m_b;
        else m_r = sregs[m_a];
      end
      sidx++;
      @(posedge clk); #1 ready = 0;
      repeat ($urandom_range(1, 5)) @(negedge clk);
      rx_data = m_r;
      done_m = 1;
      @(posedge clk); #1 done_m = 0; ready = 1;
    end
  end

  task automatic issue(input logic w, input logic [1:0] a, input logic [1:0] l,
                       input logic [31:0] wd, input logic pol, input logic pha, input logic st);
    int r;
    exp_q.delete();
    exp_q.push_back({w, 5'b0, a});
    exp_rd = 0;
    for (int i = 0; i <= int'(l); i++) begin
      r = (int'(a) + i) % 4;
      if (w) begin
        exp_q.push_back(wd[8*i +: 8]);
        mirror[r] = wd[8*i +: 8];
      end else begin
        exp_q.push_back(8'hFF);
        exp_rd[8*i +: 8] = mirror[r];
      end
    end
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_wdata = wd; cmd_cpol = pol; cmd_cpha = pha;
    cmd_valid = 1;
    mosi.delete();
    rsp_cnt = 0;
    ss_rise = 0;
    for (int k = 0; k < 1000 && !cmd_ready; k++) begin @(negedge clk); #1; end
    chk("accept", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 0;
    chk("mode", {CPOL, CPHA}, {pol, pha});
    chk("ss_low_after_accept", SS, 0);
    if (st) begin
      stray = 1;
      @(posedge clk); #1 stray = 0;
    end
    @(negedge clk); #1;
  endtask

  task automatic finish(input string tag);
    for (int k = 0; k < 2000 && rsp_cnt == 0; k++) begin @(negedge clk); #1; end
    chk({tag, "_rsp_cnt"}, rsp_cnt, 1);
    chk({tag, "_rdata"}, rsp_last, exp_rd);
    chk({tag, "_nbytes"}, mosi.size(), exp_q.size());
    for (int i = 0; i < mosi.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_mosi%0d", tag, i), mosi[i], exp_q[i]);
    chk({tag, "_ss_rises"}, ss_rise, 1);
    chk({tag, "_ready_low_close"}, cmd_ready, 0);
  endtask

  task automatic settle(input string tag);
    repeat (8) begin @(negedge clk); #1; end
    chk({tag, "_one_pulse"}, rsp_cnt, 1);
    chk({tag, "_rdata_held"}, rsp_rdata, exp_rd);
    chk({tag, "_idle"}, {cmd_ready, busy, SS}, 3'b101);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) begin @(negedge clk); #1; end
    chk("rst_ss", SS, 1);
    chk("rst_start", start, 0);
    chk("rst_tx", tx_data, 0);
    chk("rst_mode", {CPOL, CPHA}, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    reset = 1;
    @(negedge clk); #1;
    chk("rst_ready", cmd_ready, 1);
    stray = 1;
    @(posedge clk); #1 stray = 0;
    @(negedge clk); #1;
    chk("stray_idle", {cmd_ready, busy, SS, start}, 4'b1010);
    issue(1, 2'd0, 2'd3, 32'h40302010, 0, 0, 1);
    finish("t1");
    settle("t1");
    issue(0, 2'd0, 2'd3, 32'h0, 0, 0, 0);
    finish("t2");
    chk("t2_value", rsp_last, 32'h40302010);
    settle("t2");
    issue(0, 2'd3, 2'd0, 32'h0, 0, 0, 0);
    finish("t3");
    chk("t3_value", rsp_last, 32'h00000040);
    settle("t3");
    issue(1, 2'd1, 2'd1, $urandom, 0, 0, 0);
    finish("t4a");
    issue(0, 2'd0, 2'd3, 32'h0, 0, 0, 0);
    chk("t4_ss_gap", last_gap, GAP + 2);
    chk("t4_ready_low", nr_low, GAP + 1);
    finish("t4b");
    settle("t4b");
    issue(0, 2'd0, 2'd3, 32'h0, 0, 0, 0);
    for (int k = 0; k < 500 && !(mosi.size() == 3 && !ready); k++) begin @(negedge clk); #1; end
    chk("t5_reached_byte2", mosi.size(), 3);
    reset = 0;
    @(posedge clk); #1;
    chk("t5_abort", {SS, start, busy, rsp_valid}, 4'b1000);
    @(negedge clk); #1 reset = 1;
    repeat (12) begin @(negedge clk); #1; end
    chk("t5_no_rsp", rsp_cnt, 0);
    issue(0, 2'd0, 2'd3, 32'h0, 0, 0, 0);
    finish("t5n");
    settle("t5n");
    for (int n = 0; n < 10; n++) begin
      issue(1'($urandom), 2'($urandom), 2'($urandom), $urandom, 1'($urandom), 1'($urandom),
            1'($urandom));
      finish($sformatf("r%0d", n));
      if (n % 3 == 0) settle($sformatf("r%0d", n));
    end
    repeat (10) @(negedge clk);
    chk("start_only_when_ready", bad_start, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
